imem_boot_loader: RTL
=====================

Name: imem_boot_loader

Overview:
- Upstream loader for the pipelined KGP-RISC core. It streams a program image into instruction memory over a byte-wide valid/ready link.
- It holds the core in reset while loading and releases it only after the image checksum verifies.
- It replaces simulation-only $readmemh preloading, so the same image path works in simulation and on hardware.
- Sits between the host byte source and the core's imem write port and reset input.

Parameters:
- ADDR_W, 8, imem word-address width; depth DEPTH = 2**ADDR_W words of 32 bits.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  byte on in_data is valid.
- in_data  input  8  image byte.
- in_ready  output  1  loader accepts a byte this cycle.
- imem_we  output  1  one-cycle instruction-memory write strobe.
- imem_addr  output  ADDR_W  word address of the write.
- imem_wdata  output  32  instruction word to write.
- core_reset  output  1  reset to the core; high until the load succeeds.
- done  output  1  image loaded and verified.
- error  output  1  load failed (checksum mismatch or oversize count).

Behaviour:
- Image format, all little-endian:
  - CNT_LO, CNT_HI: 16-bit word count N.
  - N x 4 bytes: instruction words, LSB first.
  - CSUM: 1 byte, the XOR of every preceding byte, header included.
- A byte transfers on a rising edge with in_valid && in_ready. in_valid may drop or idle at any time.
- States and in_ready:
  - HDR_LO, HDR_HI, DATA, CSUM: in_ready = 1.
  - DONE, ERR: in_ready = 0.
  - in_ready = 0 in any cycle where reset is high.
- Reset (synchronous): on the next edge
  - state = HDR_LO; byte_idx, word_idx, count, running XOR all cleared;
  - imem_we = 0, imem_addr = 0, imem_wdata = 0, done = 0, error = 0, core_reset = 1.
- State transitions:
  - HDR_LO: accept byte -> count[7:0] -> HDR_HI.
  - HDR_HI: accept byte -> count[15:8]. Using the full 16-bit count:
    - count > DEPTH -> ERR;
    - count == 0 -> CSUM;
    - else -> DATA.
  - DATA: each accepted byte shifts into the word assembler at lane byte_idx (byte 0 -> bits 7:0). byte_idx wraps 3 -> 0.
  - On the 4th byte of a word, the following cycle drives imem_we = 1, imem_addr = word_idx[ADDR_W-1:0], imem_wdata = assembled word. word_idx then increments.
    - The write pulse is registered: latency is 1 cycle after the 4th byte is accepted.
    - The next byte may be accepted during the write-pulse cycle.
  - DATA -> CSUM on the edge that accepts the last byte of word N-1. That final write pulse still occurs in the next cycle.
  - CSUM: accept byte.
    - Equals the running XOR -> DONE.
    - Otherwise -> ERR.
  - DONE: done = 1, core_reset = 0. Held until reset.
  - ERR: error = 1, core_reset = 1. Held until reset; extra input bytes are ignored (in_ready = 0).
- Outputs:
  - done, error, core_reset are registered and change on the edge that enters DONE or ERR.
  - done and error are never both 1.
  - imem_addr and imem_wdata hold their last values when imem_we = 0.
- Boundaries:
  - count == DEPTH is legal and fills imem addresses 0..DEPTH-1 exactly.
  - count == 0 produces no writes; DONE only if CSUM == 0x00.
  - Reset mid-load aborts immediately. Already-written imem words are not erased; the next image overwrites them.
  - Writes that completed before a checksum failure remain in imem. The core stays in reset, so they are never executed.

Test Plan:
- Image 02 00 64 00 01 8C 20 18 22 00 F1, in_valid held high -> two writes: addr0 = 0x8C010064, addr1 = 0x00221820, each one cycle after its 4th byte. Then done = 1, core_reset = 0, in_ready = 0, error = 0.
- Same image with CSUM = F0 -> both writes occur; error = 1, done = 0, core_reset = 1, in_ready = 0. Further bytes are not accepted.
- Image 00 00 00 -> no imem_we pulses; done = 1, core_reset = 0.
- ADDR_W = 8, header 01 01 (count 257) -> error = 1 on the edge accepting the 2nd byte; no imem_we; in_ready = 0.
- Test 1's image with random 0-3 cycle in_valid gaps -> identical write sequence and final flags. Every byte is accepted exactly once.
- Send 6 bytes of test 1's image, assert reset for 1 cycle, then send the full image -> outputs cleared the cycle after reset; the final result matches test 1 exactly.

Source files
------------

// File: rtl/imem_boot_loader_if.sv
// Byte-stream input and imem/core-control outputs of the boot loader.
// master = loader side, slave = host byte source plus core/imem side.
interface imem_boot_loader_if #(
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_reset;
  logic              done;
  logic              error;

  modport master (
    input  in_valid, in_data,
    output in_ready, imem_we, imem_addr, imem_wdata, core_reset, done, error
  );

  modport slave (
    output in_valid, in_data,
    input  in_ready, imem_we, imem_addr, imem_wdata, core_reset, done, error
  );
endinterface

// File: rtl/imem_boot_loader.sv
// Streams a checksummed program image into imem; write pulse 1 cycle after a word's 4th byte.
// in_ready high in load states, low in DONE/ERR and during reset; core held in reset until verified.
module imem_boot_loader #(
  parameter int ADDR_W = 8
) (
  input logic                clk,
  input logic                reset,
  imem_boot_loader_if.master lb
);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [2:0] {HDR_LO, HDR_HI, DATA, CSUM, DONE, ERR} state_t;

  state_t      state, state_next;
  logic [15:0] count;
  logic [15:0] word_idx;
  logic [1:0]  byte_idx;
  logic [23:0] word_buf;
  logic [7:0]  xor_acc;
  logic        accept;
  logic        last_byte;
  logic [15:0] full_count;

  assign lb.in_ready = !reset && (state != DONE) && (state != ERR);
  assign accept      = lb.in_valid && lb.in_ready;
  assign full_count  = {lb.in_data, count[7:0]};
  assign last_byte   = (byte_idx == 2'd3) && (word_idx == count - 16'd1);

  always_ff @(posedge clk) begin
    if (reset) state <= HDR_LO;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      HDR_LO: if (accept) state_next = HDR_HI;
      HDR_HI: begin
        if (accept) begin
          if (32'(full_count) > DEPTH) state_next = ERR;
          else if (full_count == 16'd0) state_next = CSUM;
          else                          state_next = DATA;
        end
      end
      DATA: if (accept && last_byte) state_next = CSUM;
      CSUM: begin
        if (accept) state_next = (lb.in_data == xor_acc) ? DONE : ERR;
      end
      default: state_next = state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count         <= '0;
      word_idx      <= '0;
      byte_idx      <= '0;
      word_buf      <= '0;
      xor_acc       <= '0;
      lb.imem_we    <= 1'b0;
      lb.imem_addr  <= '0;
      lb.imem_wdata <= '0;
      lb.done       <= 1'b0;
      lb.error      <= 1'b0;
      lb.core_reset <= 1'b1;
    end else begin
      lb.imem_we    <= 1'b0;
      lb.done       <= (state_next == DONE);
      lb.error      <= (state_next == ERR);
      lb.core_reset <= (state_next != DONE);
      if (accept) begin
        // The checksum byte itself is excluded from the running XOR.
        if (state != CSUM) xor_acc <= xor_acc ^ lb.in_data;
        case (state)
          HDR_LO: count[7:0]  <= lb.in_data;
          HDR_HI: count[15:8] <= lb.in_data;
          DATA: begin
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
              2'd0: word_buf[7:0]   <= lb.in_data;
              2'd1: word_buf[15:8]  <= lb.in_data;
              2'd2: word_buf[23:16] <= lb.in_data;
              default: begin
                lb.imem_we    <= 1'b1;
                lb.imem_addr  <= word_idx[ADDR_W-1:0];
                lb.imem_wdata <= {lb.in_data, word_buf};
                word_idx      <= word_idx + 16'd1;
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end
endmodule
